// File: rtl/reg_file_scoreboard.sv
// Clocked register file with one write port, two registered read ports, write bypass
// and per-register busy bits. Define REG_ZERO_HARDWIRED_EN to make register 0 constant zero.

module rf_rd_port #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 4,
  parameter int NUM_REGS = 16
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [ADDR_W-1:0]                rd_addr,
  input  logic [NUM_REGS-1:0][DATA_W-1:0]  mem,
  input  logic [NUM_REGS-1:0]              busy_vec,
  input  logic                             wr_hit,
  input  logic [ADDR_W-1:0]                wr_addr,
  input  logic [DATA_W-1:0]                wr_data,
  input  logic                             rsv_hit,
  input  logic [ADDR_W-1:0]                rsv_addr,
  output logic [DATA_W-1:0]                rd_data,
  output logic                             busy
);
  logic [DATA_W-1:0] data_nxt;
  logic              busy_nxt;

  // Output reflects the register's post-edge state: bypassed data, clear-then-set busy.
  always_comb begin
    data_nxt = '0;
    busy_nxt = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (rd_addr == ADDR_W'(i)) begin
        data_nxt = mem[i];
        busy_nxt = busy_vec[i];
      end
    end
    if (wr_hit && wr_addr == rd_addr) begin
      data_nxt = wr_data;
      busy_nxt = 1'b0;
    end
    if (rsv_hit && rsv_addr == rd_addr) busy_nxt = 1'b1;
`ifdef REG_ZERO_HARDWIRED_EN
    if (rd_addr == '0) begin
      data_nxt = '0;
      busy_nxt = 1'b0;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data <= '0;
      busy    <= 1'b0;
    end else begin
      rd_data <= data_nxt;
      busy    <= busy_nxt;
    end
  end
endmodule

module reg_file_scoreboard #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 4,
  parameter int NUM_REGS = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rsv_en,
  input  logic [ADDR_W-1:0] rsv_addr,
  input  logic [ADDR_W-1:0] rd_addr1,
  input  logic [ADDR_W-1:0] rd_addr2,
  output logic [DATA_W-1:0] rd_data1,
  output logic [DATA_W-1:0] rd_data2,
  output logic              busy1,
  output logic              busy2
);
  localparam int NUM_RD = 2;
  localparam logic [ADDR_W:0] NREGS = (ADDR_W+1)'(NUM_REGS);

  logic [NUM_REGS-1:0][DATA_W-1:0] mem;
  logic [NUM_REGS-1:0]             busy_vec;
  logic                            wr_hit, rsv_hit;
  logic [NUM_RD-1:0][ADDR_W-1:0]   rd_addr_v;
  logic [NUM_RD-1:0][DATA_W-1:0]   rd_data_v;
  logic [NUM_RD-1:0]               busy_v;

  // Out-of-range (and, when hardwired, zero) addresses never touch state.
  always_comb begin
    wr_hit  = wr_en  && ({1'b0, wr_addr}  < NREGS);
    rsv_hit = rsv_en && ({1'b0, rsv_addr} < NREGS);
`ifdef REG_ZERO_HARDWIRED_EN
    if (wr_addr  == '0) wr_hit  = 1'b0;
    if (rsv_addr == '0) rsv_hit = 1'b0;
`endif
  end

  // Reserve is applied after the write so a same-cycle reservation wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem      <= '0;
      busy_vec <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (wr_hit && wr_addr == ADDR_W'(i)) begin
          mem[i]      <= wr_data;
          busy_vec[i] <= 1'b0;
        end
        if (rsv_hit && rsv_addr == ADDR_W'(i)) busy_vec[i] <= 1'b1;
      end
    end
  end

  assign rd_addr_v = {rd_addr2, rd_addr1};

  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    rf_rd_port #(
      .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_REGS(NUM_REGS)
    ) u_rd (
      .clk     (clk),
      .rst_n   (rst_n),
      .rd_addr (rd_addr_v[p]),
      .mem     (mem),
      .busy_vec(busy_vec),
      .wr_hit  (wr_hit),
      .wr_addr (wr_addr),
      .wr_data (wr_data),
      .rsv_hit (rsv_hit),
      .rsv_addr(rsv_addr),
      .rd_data (rd_data_v[p]),
      .busy    (busy_v[p])
    );
  end

  assign rd_data1 = rd_data_v[0];
  assign rd_data2 = rd_data_v[1];
  assign busy1    = busy_v[0];
  assign busy2    = busy_v[1];
endmodule

// File: tb/tb_reg_file_scoreboard.sv
// Randomized bench for reg_file_scoreboard against a register/busy array model.
// Uses 12 registers in a 4-bit address space so out-of-range addresses get exercised.

module tb_reg_file_scoreboard;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 4;
  localparam int NR     = 12;
`ifdef REG_ZERO_HARDWIRED_EN
  localparam bit HZ = 1'b1;
`else
  localparam bit HZ = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst_n;
  logic              wr_en, rsv_en;
  logic [ADDR_W-1:0] wr_addr, rsv_addr, rd_addr1, rd_addr2;
  logic [DATA_W-1:0] wr_data, rd_data1, rd_data2;
  logic              busy1, busy2;

  int n_chk = 0;
  int n_err = 0;

  logic [DATA_W-1:0] m_reg  [16];
  logic              m_busy [16];

  always #5 clk = ~clk;

  reg_file_scoreboard #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_REGS(NR)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr), .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
    .rd_data1(rd_data1), .rd_data2(rd_data2), .busy1(busy1), .busy2(busy2)
  );

  task automatic chk(input string tag, input logic [DATA_W-1:0] got, input logic [DATA_W-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic bit ok(input int a);
    return (a < NR) && !(HZ && a == 0);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) begin
      m_reg[i]  = '0;
      m_busy[i] = 1'b0;
    end
  endtask

  task automatic idle();
    wr_en = 0; wr_addr = 0; wr_data = 0; rsv_en = 0; rsv_addr = 0;
    rd_addr1 = 0; rd_addr2 = 0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".d1"}, rd_data1, '0);
    chk({tag, ".d2"}, rd_data2, '0);
    chk({tag, ".b1"}, {31'd0, busy1}, '0);
    chk({tag, ".b2"}, {31'd0, busy2}, '0);
  endtask

  // One clock: drive at negedge, update the model, check one step after the edge.
  // Read outputs equal the addressed register's state after the edge is applied.
  task automatic step(input string tag, input logic we, input int wa, input logic [DATA_W-1:0] wd,
                      input logic re, input int ra, input int a1, input int a2);
    logic [DATA_W-1:0] e1, e2;
    logic eb1, eb2;
    @(negedge clk);
    wr_en = we; wr_addr = ADDR_W'(wa); wr_data = wd;
    rsv_en = re; rsv_addr = ADDR_W'(ra);
    rd_addr1 = ADDR_W'(a1); rd_addr2 = ADDR_W'(a2);
    if (we && ok(wa)) begin m_reg[wa] = wd; m_busy[wa] = 1'b0; end
    if (re && ok(ra)) m_busy[ra] = 1'b1;
    e1  = ok(a1) ? m_reg[a1]  : '0;
    e2  = ok(a2) ? m_reg[a2]  : '0;
    eb1 = ok(a1) ? m_busy[a1] : 1'b0;
    eb2 = ok(a2) ? m_busy[a2] : 1'b0;
    @(posedge clk);
    #1;
    chk({tag, ".d1"}, rd_data1, e1);
    chk({tag, ".d2"}, rd_data2, e2);
    chk({tag, ".b1"}, {31'd0, busy1}, {31'd0, eb1});
    chk({tag, ".b2"}, {31'd0, busy2}, {31'd0, eb2});
  endtask

  initial begin
    idle();
    model_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 chk_zero("in_reset");
    @(negedge clk) rst_n = 1'b1;

    step("rst_read", 0, 0, 0, 0, 0, 3, 15);

    step("wr5", 1, 5, 32'hDEADBEEF, 0, 0, 0, 0);
    step("rd5", 0, 0, 0, 0, 0, 5, 5);
    chk("rd5.const", rd_data1, 32'hDEADBEEF);

    step("wr7", 1, 7, 32'h11, 0, 0, 7, 0);
    step("byp7", 1, 7, 32'h22, 0, 0, 0, 7);
    chk("byp7.const", rd_data2, 32'h22);

    step("rsv9", 0, 0, 0, 1, 9, 9, 0);
    chk("rsv9.const", {31'd0, busy1}, 32'd1);
    step("wr9", 1, 9, 32'h55, 0, 0, 9, 9);
    chk("wr9.busy", {31'd0, busy1}, 32'd0);
    chk("wr9.data", rd_data1, 32'h55);
    step("wrrsv9", 1, 9, 32'h66, 1, 9, 9, 9);
    chk("wrrsv9.busy", {31'd0, busy1}, 32'd1);
    chk("wrrsv9.data", rd_data1, 32'h66);
    step("hold9", 0, 0, 0, 0, 0, 9, 5);

    // Out-of-range write/reserve must not alias onto real registers.
    step("oor", 1, 13, 32'hBAD0BAD0, 1, 14, 13, 14);
    step("oor_rd", 0, 0, 0, 0, 0, 1, 2);

    step("r0", 1, 0, 32'hFFFFFFFF, 1, 0, 0, 0);
    step("r0_rd", 0, 0, 0, 0, 0, 0, 3);
`ifdef REG_ZERO_HARDWIRED_EN
    chk("r0.data", rd_data1, 32'h0);
    chk("r0.busy", {31'd0, busy1}, 32'd0);
`else
    chk("r0.data", rd_data1, 32'hFFFFFFFF);
    chk("r0.busy", {31'd0, busy1}, 32'd1);
`endif

    // Asynchronous reset between edges.
    step("pre_ar_w", 1, 2, 32'hABCD, 1, 4, 2, 4);
    step("pre_ar_r", 0, 0, 0, 0, 0, 2, 4);
    #2 rst_n = 1'b0;
    #1 chk_zero("async_rst");
    model_reset();
    idle();
    @(negedge clk);
    @(negedge clk) rst_n = 1'b1;
    step("post_ar", 0, 0, 0, 0, 0, 2, 4);

    for (int n = 0; n < 600; n++) begin
      int wa, ra, a1, a2;
      wa = $urandom_range(0, 15);
      ra = ($urandom % 3 == 0) ? wa : $urandom_range(0, 15);
      a1 = ($urandom % 3 == 0) ? wa : $urandom_range(0, 15);
      a2 = ($urandom % 4 == 0) ? a1 : (($urandom % 3 == 0) ? ra : $urandom_range(0, 15));
      step("rand", logic'($urandom % 2), wa, DATA_W'($urandom), logic'($urandom % 4 == 0), ra, a1, a2);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/reg_file_scoreboard.md
Name: reg_file_scoreboard

Overview:
- Parametrised successor to the 16x32 combinational register bank.
- Clocked register file: one write port, two registered read ports, write-to-read bypass.
- Per-register busy (scoreboard) bits let the datapath reserve a destination register for a pending result and detect source hazards.
- Sits between instruction decode (source/destination fields) and the ALU operand latches.

Parameters:
- DATA_W, 32, register width in bits.
- ADDR_W, 4, address width of every port.
- NUM_REGS, 16, number of implemented registers; must satisfy 2 <= NUM_REGS <= 2**ADDR_W.

Ports:
- clk  in  1  single clock; all state changes on its rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- wr_en  in  1  write strobe.
- wr_addr  in  ADDR_W  write destination register.
- wr_data  in  DATA_W  write data.
- rsv_en  in  1  reserve strobe; marks rsv_addr busy.
- rsv_addr  in  ADDR_W  register to reserve.
- rd_addr1  in  ADDR_W  source-1 register.
- rd_addr2  in  ADDR_W  source-2 register.
- rd_data1  out  DATA_W  source-1 data, registered.
- rd_data2  out  DATA_W  source-2 data, registered.
- busy1  out  1  source-1 busy flag, registered.
- busy2  out  1  source-2 busy flag, registered.

Behaviour:
- Reset (rst_n low, asynchronous): all registers = 0; all busy bits = 0; rd_data1/2 = 0; busy1/2 = 0. Outputs hold these values while rst_n is low.
- Write: on a rising edge with wr_en=1 and wr_addr < NUM_REGS, the register is loaded with wr_data and its busy bit is cleared.
- Reserve: on a rising edge with rsv_en=1 and rsv_addr < NUM_REGS, the busy bit is set.
- Write and reserve to the same address in the same cycle: data is written and busy ends up SET (the newer reservation wins).
- Read latency is 1 cycle. rd_dataN and busyN are sampled from rd_addrN at edge k and are valid after edge k.
- Bypass when wr_en=1 and wr_addr == rd_addrN in the same cycle: rd_dataN takes wr_data, not the old contents.
- Busy next-state for busyN, evaluated in this order:
  - start from the current busy bit;
  - clear it if a write to the same address occurs that cycle;
  - set it if a reserve to the same address occurs that cycle.
- Both read ports are independent and may use the same address; both then return identical data and busy.
- Out-of-range addresses (>= NUM_REGS): writes and reserves have no effect; reads return 0 with busy 0.
- Unchanged state: registers not written hold their value, and busy bits not written or reserved hold their value.
- Reset asserted mid-operation: clears all state immediately. The first edge after deassertion operates normally.
- No X may propagate to outputs from any legal input combination.

Optional Feature:
- Macro: REG_ZERO_HARDWIRED_EN.
- Defined: register 0 is constant 0.
  - Writes and reserves to address 0 are ignored.
  - Reads of address 0 return 0 with busy 0, including the bypass case (wr_addr=0, wr_data nonzero still reads 0).
- Undefined: register 0 is an ordinary register.

Test Plan:
- Reset then read: rst_n low 2 cycles, release; rd_addr1=3, rd_addr2=15 -> rd_data1=0, rd_data2=0, busy1=busy2=0 after next edge.
- Write then read: write 0xDEADBEEF to r5; next cycle rd_addr1=5 -> rd_data1=0xDEADBEEF one edge later.
- Bypass: r7 holds 0x11; in the same cycle wr_en=1, wr_addr=7, wr_data=0x22 and rd_addr2=7 -> rd_data2=0x22 after that edge.
- Scoreboard sequence on r9:
  - reserve r9 -> busy1=1 (rd_addr1=9);
  - write r9 = 0x55 -> busy1=0 and rd_data1=0x55 after that edge;
  - write and reserve r9 in the same cycle -> busy1=1 and rd_data1 = new data.
- Async reset mid-run: r2=0xABCD and busy set on r4; drop rst_n between edges -> outputs go 0 without a clock edge; after release, reads of r2 and r4 return 0 with busy 0.
- Macro check with REG_ZERO_HARDWIRED_EN defined: write 0xFFFFFFFF to r0 and reserve r0 -> rd_data1=0, busy1=0 for rd_addr1=0; with the macro undefined -> reads 0xFFFFFFFF with busy 1.
